// File: rtl/multi_input_comparator_seq.sv
`default_nettype none
// ============================================================================
// Module   : multi_input_comparator_seq
// Purpose  : Sequential multi-input comparator. Accepts a stream of up to M
//            unsigned N-bit operands over a valid/ready handshake. It compares
//            each new operand against the running largest one bit per cycle,
//            from MSB to LSB, and stops at the first differing bit. After the
//            last operand it reports the largest value, the arrival index of
//            that value and the operand count.
// Ports    : clk, rst                  - clock, synchronous active-high reset
//            in_valid/in_ready         - operand handshake
//            in_data, in_last          - operand and end-of-set marker
//            out_valid/out_ready       - result handshake (held until taken)
//            out_largest/index/count   - result fields
//            busy                      - high whenever not IDLE
// Revision : 1.0 - initial release
// ============================================================================
module multi_input_comparator_seq #(
    parameter int N     = 8,
    parameter int M     = 8,
    parameter int IDX_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N-1:0]     in_data,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [N-1:0]     out_largest,
    output logic [IDX_W-1:0] out_index,
    output logic [IDX_W:0]   out_count,
    output logic             busy
);

    localparam int               c_B_W      = (N > 1) ? $clog2(N) : 1;
    localparam logic [c_B_W-1:0] c_TOP_BIT  = c_B_W'(N - 1);
    localparam logic [c_B_W-1:0] c_BIT_ONE  = c_B_W'(1);
    localparam logic [IDX_W:0]   c_LAST_CNT = (IDX_W + 1)'(M - 1);
    localparam logic [IDX_W:0]   c_CNT_ONE  = (IDX_W + 1)'(1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WAIT    = 2'd1,
        ST_COMPARE = 2'd2,
        ST_DONE    = 2'd3
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;

    logic [N-1:0]       r_best;
    logic [IDX_W-1:0]   r_best_idx;
    logic [N-1:0]       r_cand;
    logic               r_cand_last;
    logic [IDX_W:0]     r_cnt;
    logic [c_B_W-1:0]   r_bit;

    logic               w_accept;
    logic               w_cand_bit;
    logic               w_best_bit;
    logic               w_cand_wins;
    logic               w_cmp_end;

    assign in_ready    = (r_state == ST_IDLE) || (r_state == ST_WAIT);
    assign out_valid   = (r_state == ST_DONE);
    assign busy        = (r_state != ST_IDLE);
    assign out_largest = r_best;
    assign out_index   = r_best_idx;
    assign out_count   = r_cnt;

    assign w_accept    = in_valid && in_ready;
    assign w_cand_bit  = r_cand[r_bit];
    assign w_best_bit  = r_best[r_bit];
    assign w_cand_wins = w_cand_bit && !w_best_bit;
    // The compare ends at the first differing bit, or after the LSB on a tie.
    assign w_cmp_end   = (r_state == ST_COMPARE) &&
                         ((w_cand_bit != w_best_bit) || (r_bit == '0));

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = (in_last || (M == 1)) ? ST_DONE : ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (w_accept) begin
                    w_state_nxt = ST_COMPARE;
                end
            end
            ST_COMPARE: begin
                if (w_cmp_end) begin
                    w_state_nxt = r_cand_last ? ST_DONE : ST_WAIT;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------------
    // State register and datapath
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_best      <= '0;
            r_best_idx  <= '0;
            r_cand      <= '0;
            r_cand_last <= 1'b0;
            r_cnt       <= '0;
            r_bit       <= '0;
        end else begin
            r_state <= w_state_nxt;
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_best     <= in_data;
                        r_best_idx <= '0;
                        r_cnt      <= c_CNT_ONE;
                    end
                end
                ST_WAIT: begin
                    if (w_accept) begin
                        r_cand      <= in_data;
                        // The M-th operand closes the set even without in_last.
                        r_cand_last <= in_last || (r_cnt == c_LAST_CNT);
                        r_bit       <= c_TOP_BIT;
                    end
                end
                ST_COMPARE: begin
                    if (w_cmp_end) begin
                        // Ties keep the earlier operand, so only a strict win swaps.
                        if (w_cand_wins) begin
                            r_best     <= r_cand;
                            r_best_idx <= r_cnt[IDX_W-1:0];
                        end
                        r_cnt <= r_cnt + c_CNT_ONE;
                    end else begin
                        r_bit <= r_bit - c_BIT_ONE;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_multi_input_comparator_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_multi_input_comparator_seq
// Purpose  : Self-checking bench for multi_input_comparator_seq. Directed sets
//            plus randomized sets are checked against a behavioural model
//            (running maximum with first-index tie-break, and per-operand
//            compare latency from the highest differing bit).
// Revision : 1.0 - initial release
// ============================================================================
module tb_multi_input_comparator_seq;

    localparam int N     = 8;
    localparam int M     = 8;
    localparam int IDX_W = 3;

    logic             clk;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [N-1:0]     in_data;
    logic             in_last;
    logic             out_valid;
    logic             out_ready;
    logic [N-1:0]     out_largest;
    logic [IDX_W-1:0] out_index;
    logic [IDX_W:0]   out_count;
    logic             busy;

    int n_checks = 0;
    int n_fail   = 0;

    multi_input_comparator_seq #(.N(N), .M(M), .IDX_W(IDX_W)) u_dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .in_last     (in_last),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_largest (out_largest),
        .out_index   (out_index),
        .out_count   (out_count),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Cycles a compare takes: N - (highest differing bit), N when equal.
    function automatic int cmp_latency(input logic [N-1:0] a, input logic [N-1:0] b);
        for (int p = N - 1; p >= 0; p--) begin
            if (a[p] != b[p]) return N - p;
        end
        return N;
    endfunction

    // Called at a negedge; returns at a negedge after the compare settles.
    task automatic push(input logic [N-1:0] d, input logic l, input int exp_lat, input string tag);
        int t;
        t = 0;
        while (!in_ready && t < 100) begin
            @(negedge clk);
            t++;
        end
        check({tag, "_ready_wait"}, 32'(t < 100), 32'd1);
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        @(negedge clk);
        in_valid = 1'b0;
        in_data  = N'($urandom);
        in_last  = 1'($urandom);
        t = 0;
        while (!in_ready && !out_valid && t < 100) begin
            @(negedge clk);
            t++;
        end
        check({tag, "_latency"}, 32'(t), 32'(exp_lat));
    endtask

    task automatic run_set(input logic [N-1:0] d [M], input int n, input bit last_final,
                           input int hold, input int gaps, input string tag);
        logic [N-1:0] best;
        int           best_idx;
        int           elat;
        int           t;
        logic         l;
        best     = d[0];
        best_idx = 0;
        for (int k = 0; k < n; k++) begin
            l = (k == n - 1) && last_final;
            if (k == 0) begin
                elat = 0;
            end else begin
                elat = cmp_latency(d[k], best);
                if (d[k] > best) begin
                    best     = d[k];
                    best_idx = k;
                end
                repeat (gaps > 0 ? $urandom_range(0, gaps) : 0) @(negedge clk);
            end
            push(d[k], l, elat, tag);
        end
        t = 0;
        while (!out_valid && t < 100) begin
            @(negedge clk);
            t++;
        end
        check({tag, "_out_valid"}, 32'(out_valid), 32'd1);
        for (int h = 0; h <= hold; h++) begin
            check({tag, "_largest"}, 32'(out_largest), 32'(best));
            check({tag, "_index"},   32'(out_index),   32'(best_idx));
            check({tag, "_count"},   32'(out_count),   32'(n));
            check({tag, "_in_ready_done"}, 32'(in_ready), 32'd0);
            check({tag, "_busy_done"}, 32'(busy), 32'd1);
            if (h < hold) begin
                @(negedge clk);
                check({tag, "_valid_held"}, 32'(out_valid), 32'd1);
            end
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check({tag, "_valid_cleared"}, 32'(out_valid), 32'd0);
        check({tag, "_ready_after"},   32'(in_ready),  32'd1);
        check({tag, "_busy_after"},    32'(busy),      32'd0);
    endtask

    initial begin
        logic [N-1:0] arr [M];
        int           n;
        bit           lf;

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        in_last   = 1'b0;
        out_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_in_ready",  32'(in_ready),    32'd1);
        check("rst_out_valid", 32'(out_valid),   32'd0);
        check("rst_busy",      32'(busy),        32'd0);
        check("rst_largest",   32'(out_largest), 32'd0);
        check("rst_index",     32'(out_index),   32'd0);
        check("rst_count",     32'(out_count),   32'd0);
        rst = 1'b0;
        @(negedge clk);

        arr = '{8'hA5, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        run_set(arr, 1, 1'b1, 0, 0, "single");
        arr = '{8'h10, 8'h80, 8'h7F, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        run_set(arr, 3, 1'b1, 0, 0, "msb_diff");
        arr = '{8'h3C, 8'h3C, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        run_set(arr, 2, 1'b1, 0, 0, "tie");
        arr = '{8'h40, 8'h41, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        run_set(arr, 2, 1'b1, 5, 0, "lsb_hold");
        arr = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8};
        run_set(arr, 8, 1'b0, 0, 0, "overflow");

        // Reset in the middle of a compare (0x02 vs 0x01 takes 7 cycles).
        push(8'h01, 1'b0, 0, "rst_mid_a");
        in_valid = 1'b1;
        in_data  = 8'h02;
        in_last  = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        check("rst_mid_in_compare", 32'(in_ready), 32'd0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rst_mid_busy",      32'(busy),      32'd0);
        check("rst_mid_in_ready",  32'(in_ready),  32'd1);
        check("rst_mid_out_valid", 32'(out_valid), 32'd0);
        check("rst_mid_count",     32'(out_count), 32'd0);
        arr = '{8'h05, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        run_set(arr, 1, 1'b1, 0, 0, "after_rst");

        // Randomized sets, with frequent repeats to exercise ties.
        for (int s = 0; s < 25; s++) begin
            n = $urandom_range(1, M);
            for (int k = 0; k < M; k++) begin
                if (k > 0 && ($urandom_range(0, 3) == 0)) arr[k] = arr[$urandom_range(0, k - 1)];
                else                                      arr[k] = N'($urandom);
            end
            lf = (n < M) ? 1'b1 : 1'($urandom);
            run_set(arr, n, lf, $urandom_range(0, 3), 2, "rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/multi_input_comparator_seq.md
# multi_input_comparator_seq

Sequential multi-input digital comparator. Accepts a stream of up to M unsigned N-bit operands over a valid/ready handshake. Compares each new operand against the running largest bit-serially, from MSB to LSB, one bit per cycle, and stops at the first differing bit. After the operand flagged last, it reports the largest value, its index and the operand count. It sits upstream of the consumers of the two-input combinational comparator results and covers the multi-input, time-multiplexed case.

## Interface
- N, 8, operand width in bits (N >= 2)
- M, 8, maximum operands per set (M >= 2)
- IDX_W, 3, index width; IDX_W = clog2(M)
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  operand valid
- in_ready  output  1  block can accept an operand
- in_data  input  N  unsigned operand
- in_last  input  1  marks the final operand of the set
- out_valid  output  1  result valid; held until out_ready
- out_ready  input  1  result consumed
- out_largest  output  N  largest operand of the set
- out_index  output  IDX_W  0-based arrival index of the largest operand
- out_count  output  IDX_W+1  number of operands in the set
- busy  output  1  high in every state except IDLE

## Operation
- There is one clock. Reset is synchronous and active-high.
- States: IDLE, WAIT, COMPARE, DONE. in_ready = (state == IDLE || state == WAIT), decoded from the registered state. out_valid = (state == DONE).
- An operand is accepted on a clock edge where in_valid && in_ready.
- IDLE: on accept, best <= in_data, best_idx <= 0, cnt <= 1.
  - If in_last is set, or M == 1 is reached, go to DONE. Otherwise go to WAIT.
- WAIT: on accept, cand <= in_data, cand_last <= in_last || (cnt == M-1), bit pointer b <= N-1. Go to COMPARE.
- COMPARE: each cycle, examine cand[b] against best[b]:
  - cand[b]=1, best[b]=0: best <= cand, best_idx <= cnt. End compare.
  - cand[b]=0, best[b]=1: end compare. best is unchanged.
  - Bits equal with b > 0: b <= b-1. Stay in COMPARE.
  - Bits equal with b == 0: tie. Keep the earlier best and index. End compare.
  - End compare: cnt <= cnt+1. Next state is DONE if cand_last, otherwise WAIT.
- DONE: out_largest = best, out_index = best_idx, out_count = cnt. These are stable while out_valid is high. When out_valid && out_ready, go to IDLE.
- Overflow: the M-th operand is treated as last whether or not in_last is set, so cnt never exceeds M.
- Inputs are sampled only on accept. in_data may change freely at other times.
- rst in any state: the next state is IDLE, partial results are discarded, and outputs return to their reset values.

## Timing
- Reset values:
  - in_ready=1 once out of reset (state IDLE)
  - out_valid=0, out_largest=0, out_index=0, out_count=0, busy=0
- All outputs are registered or decoded from registered state. There is no combinational path from inputs to outputs.
- Compare latency per operand after the first: N-p cycles, where p is the highest bit position at which cand and best differ. It is N cycles when they are equal.
- in_ready is low throughout COMPARE. It rises on the cycle after the final compare cycle when entering WAIT.
- out_valid rises on the cycle after the final compare cycle of the last operand. For a single-operand set, it rises on the cycle after acceptance.
- out_valid stays high indefinitely while out_ready is low. in_ready stays low in DONE.
- On a DONE-exit edge, in_ready goes high on the next cycle. A new set cannot be accepted in the same cycle as result consumption.

## Test plan
- Single operand 0xA5 with in_last set:
  - out_valid one cycle after accept; out_largest=0xA5, out_index=0, out_count=1.
- Operands 0x10, 0x80, 0x7F(last):
  - Each compare takes 1 cycle (bit 7 differs).
  - Result out_largest=0x80, out_index=1, out_count=3.
- Operands 0x3C, 0x3C(last):
  - Compare takes 8 cycles.
  - Result out_largest=0x3C, out_index=0 (tie keeps earlier), out_count=2.
- Operands 0x40, 0x41(last):
  - Compare takes 8 cycles (LSB difference).
  - Result out_largest=0x41, out_index=1.
  - Additionally hold out_ready low for 5 cycles: outputs stay stable and in_ready stays 0.
- Eight operands 1..8 with in_last never asserted, M=8:
  - Forced done after the 8th operand.
  - Result out_largest=8, out_index=7, out_count=8.
- Assert rst for 1 cycle mid-COMPARE (set 0x01, 0x02):
  - Next cycle busy=0, in_ready=1, out_valid=0.
  - A following set 0x05(last) yields out_largest=0x05, out_count=1.
